// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    PC_STEP   = 9'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // FETCH  : request outstanding at pc
    // DISCARD: a redirect hit a pending request; drain it, drop the data
    // HOLD   : consumer stalled on an acked word, parked in the skid buffer
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/ack bus
//
// master (fetch unit): drives imem_req, imem_addr; samples imem_ack, imem_rdata
// slave  (memory)    : samples imem_req, imem_addr; drives imem_ack, imem_rdata
interface instr_fetch_unit_if;
    import ifu_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid register for an acked instruction
//
// Ports: clk, reset (sync, active-high); load captures {data_in, pc_in};
// clear invalidates (load wins if both); valid/data/pc present the entry.
module fetch_skid_buf
    import ifu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] data_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] data,
    output logic [PC_W-1:0]    pc
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
            pc_d    = pc_in;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-issue instruction fetch with skid and redirect
//
// Ports: clk, reset (sync, active-high); stall (consumer not loading);
// redirect/redirect_pc (flush and refetch); imem (master side of the memory
// bus); instr_out/pc_out/instr_valid (registered decode-stage outputs);
// fetch_wait_cnt (16-bit saturating wait counter, only with IFU_WAIT_CNT_EN).
module instr_fetch_unit
    import ifu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    instr_fetch_unit_if.master imem,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid
`ifdef IFU_WAIT_CNT_EN
    ,
    output logic [15:0]        fetch_wait_cnt
`endif
);

    ifu_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    disc_addr_q, disc_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    // Set through reset and for the first cycle after it, so an ack left
    // over from an abandoned transaction cannot be taken as ours.
    logic               ign_q;

    logic               req;
    logic               ack_ok;
    logic               skid_load;
    logic               skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_data;
    logic [PC_W-1:0]    skid_pc;

    // imem_addr depends only on registered state, never on stall or ack.
    assign req    = !reset && !ign_q && (state_q != HOLD);
    assign ack_ok = req && imem.imem_ack;

    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .data_in (imem.imem_rdata),
        .pc_in   (pc_q),
        .valid   (skid_valid),
        .data    (skid_data),
        .pc      (skid_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;

        // A loading consumer with nothing new gets a bubble.
        if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (redirect) begin
            pc_d       = redirect_pc & ~9'h003;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            pc_out_d   = '0;
            skid_clear = 1'b1;
            unique case (state_q)
                FETCH: begin
                    if (req && !imem.imem_ack) begin
                        state_d     = DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                DISCARD: begin
                    if (ack_ok) state_d = FETCH;
                end
                HOLD:    state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack_ok) begin
                        pc_d = pc_q + PC_STEP;
                        if (!stall) begin
                            instr_d  = imem.imem_rdata;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                DISCARD: begin
                    if (ack_ok) state_d = FETCH;
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d    = skid_data;
                        pc_out_d   = skid_pc;
                        valid_d    = skid_valid;
                        skid_clear = 1'b1;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            disc_addr_q <= '0;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
            ign_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            ign_q       <= 1'b0;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

`ifdef IFU_WAIT_CNT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (req && !imem.imem_ack && (wait_cnt_q != 16'hFFFF))
            wait_cnt_d = wait_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) wait_cnt_q <= 16'h0000;
        else       wait_cnt_q <= wait_cnt_d;
    end

    assign fetch_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic               instr_valid;
`ifdef IFU_WAIT_CNT_EN
    logic [15:0]        fetch_wait_cnt;
`endif

    instr_fetch_unit_if imem ();

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
`ifdef IFU_WAIT_CNT_EN
        ,
        .fetch_wait_cnt (fetch_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        st;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [8:0]  e_addr;
        logic        e_v;
        logic [31:0] e_i;
        logic [8:0]  e_p;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs just after an edge, bus outputs checked
    // mid-cycle, registered outputs checked 1ns after the next edge.
    task automatic step(input logic st, input logic rd, input logic [8:0] rpc,
                        input logic ack, input logic [31:0] rdata,
                        input logic e_req, input logic [8:0] e_addr,
                        input logic e_v, input logic [31:0] e_i, input logic [8:0] e_p,
                        input string name);
        stall           = st;
        redirect        = rd;
        redirect_pc     = rpc;
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;
        #3;
        chk({name, "_req"}, {31'b0, imem.imem_req}, {31'b0, e_req});
        if (e_req) chk({name, "_addr"}, {23'b0, imem.imem_addr}, {23'b0, e_addr});
        @(posedge clk);
        #1;
        chk({name, "_valid"}, {31'b0, instr_valid}, {31'b0, e_v});
        chk({name, "_instr"}, instr_out, e_i);
        chk({name, "_pc"}, {23'b0, pc_out}, {23'b0, e_p});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;

        //            st  ack  rdata          req addr   v  instr          pc_out
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 9'h000, 1'b0, 32'h0,        9'h000};
        vecs[1]  = '{1'b0, 1'b1, 32'h20010005, 1'b1, 9'h000, 1'b1, 32'h20010005, 9'h000};
        vecs[2]  = '{1'b0, 1'b1, 32'h8C220004, 1'b1, 9'h004, 1'b1, 32'h8C220004, 9'h004};
        vecs[3]  = '{1'b1, 1'b1, 32'h11110008, 1'b1, 9'h008, 1'b1, 32'h8C220004, 9'h004};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 1'b1, 32'h8C220004, 9'h004};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 1'b1, 32'h8C220004, 9'h004};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 9'h000, 1'b1, 32'h11110008, 9'h008};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 9'h00C, 1'b0, 32'h0,        9'h008};
        vecs[8]  = '{1'b0, 1'b1, 32'h2222000C, 1'b1, 9'h00C, 1'b1, 32'h2222000C, 9'h00C};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 9'h010, 1'b1, 32'h2222000C, 9'h00C};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 9'h010, 1'b0, 32'h0,        9'h00C};

        // Reset state
        #3;
        chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc", {23'b0, pc_out}, 32'h0);
`ifdef IFU_WAIT_CNT_EN
        chk("rst_cnt", {16'b0, fetch_wait_cnt}, 32'h0);
`endif
        reset = 1'b0;

        // Streaming, stall with skid, bubbles
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].st, 1'b0, 9'h000, vecs[i].ack, vecs[i].rdata,
                 vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_i, vecs[i].e_p,
                 $sformatf("vec%0d", i));
        end

        // Redirect while waiting on pc=16: drain old request, drop its data
        step(1'b0, 1'b1, 9'h043, 1'b0, 32'h0,        1'b1, 9'h010, 1'b0, 32'h0, 9'h000, "disc0");
        step(1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 9'h010, 1'b0, 32'h0, 9'h000, "disc1");
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'hDEADDEAD, 1'b1, 9'h010, 1'b0, 32'h0, 9'h000, "disc2");
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'h33330040, 1'b1, 9'h040, 1'b1, 32'h33330040, 9'h040, "disc3");

        // Redirect coincident with ack under stall
        step(1'b1, 1'b1, 9'h100, 1'b1, 32'hBEEFBEEF, 1'b1, 9'h044, 1'b0, 32'h0, 9'h000, "rdack0");
        step(1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 9'h100, 1'b0, 32'h0, 9'h000, "rdack1");

        // PC wrap at 9 bits
        step(1'b0, 1'b1, 9'h1F8, 1'b1, 32'hBAD0BAD0, 1'b1, 9'h100, 1'b0, 32'h0, 9'h000, "wrap0");
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'h555501F8, 1'b1, 9'h1F8, 1'b1, 32'h555501F8, 9'h1F8, "wrap1");
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'h555501FC, 1'b1, 9'h1FC, 1'b1, 32'h555501FC, 9'h1FC, "wrap2");
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'h55550000, 1'b1, 9'h000, 1'b1, 32'h55550000, 9'h000, "wrap3");
        step(1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 9'h004, 1'b1, 32'h55550000, 9'h000, "wrap4");

        // Reset mid-wait with stall high, then a late ack
        reset = 1'b1;
        step(1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b0, 9'h000, 1'b0, 32'h0, 9'h000, "midrst");
        reset = 1'b0;
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'h77777777, 1'b0, 9'h000, 1'b0, 32'h0, 9'h000, "late");
        step(1'b0, 1'b0, 9'h000, 1'b1, 32'h66660000, 1'b1, 9'h000, 1'b1, 32'h66660000, 9'h000, "post");

        // Ten fetches with one wait cycle each
        for (int k = 1; k <= 10; k++) begin
            logic [8:0]  a;
            logic [31:0] w;
            a = 9'(k * 4);
            w = 32'hC0DE0000 | {23'b0, a};
            step(1'b0, 1'b0, 9'h000, 1'b0, 32'h0, 1'b1, a, 1'b0, 32'h0, 9'(a - 9'd4),
                 $sformatf("lat%0d_w", k));
            step(1'b0, 1'b0, 9'h000, 1'b1, w,     1'b1, a, 1'b1, w,     a,
                 $sformatf("lat%0d_a", k));
        end
`ifdef IFU_WAIT_CNT_EN
        chk("wait_cnt", {16'b0, fetch_wait_cnt}, 32'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
